// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared constants and types for the AES word bridge:
//   AES_WORDS  - 32-bit words per 128-bit AES block
//   WORD_W     - stream word width
//   BLOCK_W    - AES block width
//   CNT_W      - width of the per-block word counters (holds 0..AES_WORDS)
//   state_e    - bridge FSM states
//   block_word - selects word idx of a block, word 0 being the MSW
// -----------------------------------------------------------------------------
package aes_pkg;

  localparam int AES_WORDS = 4;
  localparam int WORD_W    = 32;
  localparam int BLOCK_W   = AES_WORDS * WORD_W;
  localparam int CNT_W     = 3;

  typedef enum logic [2:0] {
    LOAD_KEY = 3'd0,
    LOAD_PT  = 3'd1,
    START    = 3'd2,
    WAIT     = 3'd3,
    DRAIN    = 3'd4
  } state_e;

  // Big-endian word select: index 0 returns bits [127:96].
  function automatic logic [WORD_W-1:0] block_word(input logic [BLOCK_W-1:0] blk,
                                                   input logic [1:0]         idx);
    logic [WORD_W-1:0] w;
    case (idx)
      2'd0:    w = blk[127:96];
      2'd1:    w = blk[95:64];
      2'd2:    w = blk[63:32];
      2'd3:    w = blk[31:0];
      default: w = blk[127:96];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/aes_word_bridge_if.sv
// -----------------------------------------------------------------------------
// aes_word_bridge_if
// Word-stream handshake bundle of the AES word bridge.
//   s_valid/s_ready/s_data/s_key : upstream key/plaintext words
//   m_valid/m_ready/m_data/m_last: downstream ciphertext words
// Modports:
//   slave  - the bridge's view (consumes s_*, produces m_*)
//   master - the environment's view (produces s_*, consumes m_*)
// -----------------------------------------------------------------------------
interface aes_word_bridge_if;
  import aes_pkg::*;

  logic              s_valid;
  logic              s_ready;
  logic [WORD_W-1:0] s_data;
  logic              s_key;
  logic              m_valid;
  logic              m_ready;
  logic [WORD_W-1:0] m_data;
  logic              m_last;

  modport master (
    output s_valid, s_data, s_key, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  s_valid, s_data, s_key, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

endinterface

// File: rtl/aes_word_pack.sv
// -----------------------------------------------------------------------------
// aes_word_pack
// 4x32 shift-in register with a word counter. Each shift pushes word_i into
// the LSW and moves older words up, so the first of four words ends in
// bits [127:96].
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   clr_i         - restart the word count (combined with shift_i the word
//                   being shifted counts as word 1)
//   shift_i       - accept word_i
//   word_i        - incoming 32-bit word
//   block_o       - assembled 128-bit block
//   count_o       - words held (0..4)
//   count_next_o  - value count_o takes after this clock edge
// -----------------------------------------------------------------------------
module aes_word_pack
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               shift_i,
  input  logic [WORD_W-1:0]  word_i,
  output logic [BLOCK_W-1:0] block_o,
  output logic [CNT_W-1:0]   count_o,
  output logic [CNT_W-1:0]   count_next_o
);

  logic [BLOCK_W-1:0] block_q, block_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // Next block contents and word count.
  always_comb begin
    block_d = block_q;
    count_d = count_q;
    if (shift_i) begin
      block_d = {block_q[BLOCK_W-WORD_W-1:0], word_i};
    end else begin
      block_d = block_q;
    end
    if (clr_i) begin
      count_d = shift_i ? CNT_W'(1) : CNT_W'(0);
    end else if (shift_i) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Block and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      block_q <= {BLOCK_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
    end else begin
      block_q <= block_d;
      count_q <= count_d;
    end
  end

  assign block_o      = block_q;
  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/aes_word_bridge.sv
// -----------------------------------------------------------------------------
// aes_word_bridge
// Collects four 32-bit key words and four plaintext words from a valid/ready
// stream, starts an AES engine, waits for its result and streams the 128-bit
// ciphertext back out as four words, MSW first.
// Parameters:
//   WAIT_LIMIT     - cycles to wait for aes_valid before giving up
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   bus            - aes_word_bridge_if.slave (upstream s_*, downstream m_*)
//   aes_start      - one-cycle engine start pulse
//   aes_key        - assembled key
//   aes_plaintext  - assembled plaintext
//   aes_ciphertext - engine result
//   aes_valid      - engine result strobe (only honoured while waiting)
//   busy           - bridge holds or processes a block
//   timeout_err    - sticky engine timeout flag, cleared only by reset
// Build option:
//   AES_KEY_REUSE_EN - keep the key between blocks; a word flagged s_key at
//                      the start of a plaintext load begins a new key.
// -----------------------------------------------------------------------------
module aes_word_bridge
  import aes_pkg::*;
#(
  parameter int WAIT_LIMIT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  aes_word_bridge_if.slave   bus,
  output logic               aes_start,
  output logic [BLOCK_W-1:0] aes_key,
  output logic [BLOCK_W-1:0] aes_plaintext,
  input  logic [BLOCK_W-1:0] aes_ciphertext,
  input  logic               aes_valid,
  output logic               busy,
  output logic               timeout_err
);

  localparam int                WAIT_W   = $clog2(WAIT_LIMIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_END = WAIT_W'(WAIT_LIMIT - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(AES_WORDS - 1);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [1:0]          idx_q, idx_d;
  logic [BLOCK_W-1:0]  ct_q, ct_d;
  logic                timeout_err_q, timeout_err_d;
  logic                s_ready_q, s_ready_d;
  logic                aes_start_q, aes_start_d;
  logic                m_valid_q, m_valid_d;
  logic [WORD_W-1:0]   m_data_q, m_data_d;
  logic                m_last_q, m_last_d;
  logic                busy_q, busy_d;

  logic                accept_s;
  logic                key_clr_s, key_shift_s;
  logic                pt_clr_s, pt_shift_s;
  logic [CNT_W-1:0]    kc_s, kc_next_s;
  logic [CNT_W-1:0]    pc_s, pc_next_s;
  logic [BLOCK_W-1:0]  key_blk_s, pt_blk_s;
  state_e              ret_state_s;
  logic                ret_key_clr_s;
  logic                key_switch_s;
  logic                idle_s;

  assign accept_s = s_ready_q && bus.s_valid;

  aes_word_pack u_key_pack (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (key_clr_s),
    .shift_i      (key_shift_s),
    .word_i       (bus.s_data),
    .block_o      (key_blk_s),
    .count_o      (kc_s),
    .count_next_o (kc_next_s)
  );

  aes_word_pack u_pt_pack (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (pt_clr_s),
    .shift_i      (pt_shift_s),
    .word_i       (bus.s_data),
    .block_o      (pt_blk_s),
    .count_o      (pc_s),
    .count_next_o (pc_next_s)
  );

`ifdef AES_KEY_REUSE_EN
  logic key_held_s;
  // A complete key survives the block; only the plaintext is reloaded.
  assign key_held_s    = (kc_s == CNT_W'(AES_WORDS));
  assign ret_state_s   = key_held_s ? LOAD_PT : LOAD_KEY;
  assign ret_key_clr_s = !key_held_s;
  // s_key only means "new key" before any plaintext word of the block.
  assign key_switch_s  = bus.s_key && (pc_s == CNT_ZERO);
  // Waiting for plaintext with a retained key counts as idle.
  assign idle_s        = ((state_d == LOAD_KEY) && (kc_next_s == CNT_ZERO)) ||
                         ((state_d == LOAD_PT)  && (pc_next_s == CNT_ZERO));
`else
  logic unused_s;
  assign ret_state_s   = LOAD_KEY;
  assign ret_key_clr_s = 1'b1;
  assign key_switch_s  = 1'b0;
  assign idle_s        = (state_d == LOAD_KEY) && (kc_next_s == CNT_ZERO);
  assign unused_s      = ^{bus.s_key, pc_next_s};
`endif

  // State register and block datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= LOAD_KEY;
      wait_cnt_q    <= {WAIT_W{1'b0}};
      idx_q         <= 2'd0;
      ct_q          <= {BLOCK_W{1'b0}};
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      idx_q         <= idx_d;
      ct_q          <= ct_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state logic, pack controls, wait counter and ciphertext capture.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    idx_d         = idx_q;
    ct_d          = ct_q;
    timeout_err_d = timeout_err_q;
    key_clr_s     = 1'b0;
    key_shift_s   = 1'b0;
    pt_clr_s      = 1'b0;
    pt_shift_s    = 1'b0;
    case (state_q)
      LOAD_KEY: begin
        if (accept_s) begin
          key_shift_s = 1'b1;
          if (kc_s == CNT_LAST) begin
            state_d = LOAD_PT;
          end else begin
            state_d = LOAD_KEY;
          end
        end else begin
          state_d = LOAD_KEY;
        end
      end
      LOAD_PT: begin
        if (accept_s && key_switch_s) begin
          // The flagged word restarts the key and is its first word.
          key_clr_s   = 1'b1;
          key_shift_s = 1'b1;
          state_d     = LOAD_KEY;
        end else if (accept_s) begin
          pt_shift_s = 1'b1;
          if (pc_s == CNT_LAST) begin
            state_d = START;
          end else begin
            state_d = LOAD_PT;
          end
        end else begin
          state_d = LOAD_PT;
        end
      end
      START: begin
        state_d    = WAIT;
        wait_cnt_d = {WAIT_W{1'b0}};
      end
      WAIT: begin
        if (aes_valid) begin
          ct_d    = aes_ciphertext;
          idx_d   = 2'd0;
          state_d = DRAIN;
        end else if (wait_cnt_q == WAIT_END) begin
          // Engine never answered: drop the block and flag it.
          timeout_err_d = 1'b1;
          state_d       = ret_state_s;
          key_clr_s     = ret_key_clr_s;
          pt_clr_s      = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      DRAIN: begin
        if (m_valid_q && bus.m_ready) begin
          if (idx_q == 2'd3) begin
            state_d   = ret_state_s;
            key_clr_s = ret_key_clr_s;
            pt_clr_s  = 1'b1;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d   = LOAD_KEY;
        key_clr_s = 1'b1;
        pt_clr_s  = 1'b1;
      end
    endcase
  end

  // Output decode from the next state so every output comes straight off a flop.
  always_comb begin
    s_ready_d   = (state_d == LOAD_KEY) || (state_d == LOAD_PT);
    aes_start_d = (state_d == START);
    busy_d      = !idle_s;
    if (state_d == DRAIN) begin
      m_valid_d = 1'b1;
      m_data_d  = block_word(ct_d, idx_d);
      m_last_d  = (idx_d == 2'd3);
    end else begin
      m_valid_d = 1'b0;
      m_data_d  = {WORD_W{1'b0}};
      m_last_d  = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready_q   <= 1'b0;
      aes_start_q <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= {WORD_W{1'b0}};
      m_last_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      s_ready_q   <= s_ready_d;
      aes_start_q <= aes_start_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_last_q    <= m_last_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.s_ready    = s_ready_q;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_data     = m_data_q;
  assign bus.m_last     = m_last_q;
  assign aes_start      = aes_start_q;
  assign aes_key        = key_blk_s;
  assign aes_plaintext  = pt_blk_s;
  assign busy           = busy_q;
  assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_aes_word_bridge.sv
// -----------------------------------------------------------------------------
// tb_aes_word_bridge
// Directed bench for aes_word_bridge with WAIT_LIMIT = 8. Inputs are driven
// and outputs sampled on the falling clock edge. The AES engine is a stand-in
// that returns a known ciphertext for the FIPS-197 vectors used.
// -----------------------------------------------------------------------------
module tb_aes_word_bridge;

  localparam int WAIT_LIMIT = 8;

  localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         aes_start;
  logic [127:0] aes_key;
  logic [127:0] aes_plaintext;
  logic [127:0] aes_ciphertext = 128'h0;
  logic         aes_valid = 1'b0;
  logic         busy;
  logic         timeout_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  aes_word_bridge_if bus ();

  aes_word_bridge #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .aes_start      (aes_start),
    .aes_key        (aes_key),
    .aes_plaintext  (aes_plaintext),
    .aes_ciphertext (aes_ciphertext),
    .aes_valid      (aes_valid),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [127:0] b, input int i);
    return b[127 - 32*i -: 32];
  endfunction

  // Called on a falling edge; returns on the falling edge after the word is taken.
  task automatic send_word(input logic [31:0] d, input logic k);
    int n;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_key   = k;
    n = 0;
    while (bus.s_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check_eq("s_ready_wait", bus.s_ready, 1'b1);
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_key   = 1'b0;
  endtask

  task automatic load_block(input logic [127:0] key, input logic [127:0] pt, input bit with_key);
    int c0;
    c0 = cyc;
    if (with_key) begin
      for (int i = 0; i < 4; i++) begin
        send_word(word_of(key, i), 1'b1);
        if (i == 0) check_eq("busy_loading", busy, 1'b1);
      end
    end
    for (int i = 0; i < 4; i++) send_word(word_of(pt, i), 1'b0);
    check_eq("load_rate", cyc - c0, with_key ? 8 : 4);
  endtask

  task automatic drain_block(input logic [127:0] ct, input int stall_word,
                             input int stall_cycles, input int nwords);
    for (int i = 0; i < nwords; i++) begin
      if (i == stall_word) begin
        bus.m_ready = 1'b0;
        for (int s = 0; s < stall_cycles; s++) begin
          check_eq("stall_valid", bus.m_valid, 1'b1);
          check_eq("stall_data", bus.m_data, word_of(ct, i));
          check_eq("stall_last", bus.m_last, 1'b0);
          @(negedge clk);
        end
        bus.m_ready = 1'b1;
      end
      check_eq("m_valid", bus.m_valid, 1'b1);
      check_eq("m_data", bus.m_data, word_of(ct, i));
      check_eq("m_last", bus.m_last, (i == 3));
      @(negedge clk);
    end
  endtask

  task automatic do_block(input logic [127:0] key, input logic [127:0] pt, input logic [127:0] ct,
                          input bit with_key, input int stall_word, input int stall_cycles,
                          input int nwords);
    load_block(key, pt, with_key);
    check_eq("start_pulse", aes_start, 1'b1);
    check_eq("aes_key", aes_key, key);
    check_eq("aes_plaintext", aes_plaintext, pt);
    @(negedge clk);
    check_eq("start_single", aes_start, 1'b0);
    check_eq("wait_no_valid", bus.m_valid, 1'b0);
    check_eq("wait_no_ready", bus.s_ready, 1'b0);
    @(negedge clk);
    aes_ciphertext = ct;
    aes_valid      = 1'b1;
    @(negedge clk);
    aes_valid      = 1'b0;
    aes_ciphertext = 128'h0;
    check_eq("key_stable", aes_key, key);
    drain_block(ct, stall_word, stall_cycles, nwords);
    if (nwords == 4) begin
      check_eq("drain_done_valid", bus.m_valid, 1'b0);
      check_eq("drain_done_ready", bus.s_ready, 1'b1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = 32'h0;
    bus.s_key   = 1'b0;
    bus.m_ready = 1'b1;

    // Reset values.
    repeat (3) @(negedge clk);
    check_eq("rst_s_ready", bus.s_ready, 1'b0);
    check_eq("rst_aes_start", aes_start, 1'b0);
    check_eq("rst_m_valid", bus.m_valid, 1'b0);
    check_eq("rst_m_last", bus.m_last, 1'b0);
    check_eq("rst_m_data", bus.m_data, 32'h0);
    check_eq("rst_aes_key", aes_key, 128'h0);
    check_eq("rst_aes_pt", aes_plaintext, 128'h0);
    check_eq("rst_timeout", timeout_err, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_s_ready", bus.s_ready, 1'b1);
    check_eq("post_rst_busy", busy, 1'b0);

    // Stray engine strobe while loading keys must be ignored.
    aes_ciphertext = CT2;
    aes_valid      = 1'b1;
    @(negedge clk);
    aes_valid      = 1'b0;
    aes_ciphertext = 128'h0;
    check_eq("spurious_m_valid", bus.m_valid, 1'b0);
    check_eq("spurious_s_ready", bus.s_ready, 1'b1);
    check_eq("spurious_busy", busy, 1'b0);

    // FIPS-197 vector, full-rate drain.
    do_block(KEY1, PT1, CT1, 1'b1, -1, 0, 4);

    // Same vector with word 2 back-pressured for 3 cycles.
    do_block(KEY1, PT1, CT1, 1'b1, 1, 3, 4);

    // Engine never answers: timeout after WAIT_LIMIT cycles in WAIT.
    load_block(KEY2, PT2, 1'b1);
    check_eq("to_start", aes_start, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 7) begin
        check_eq("to_early_flag", timeout_err, 1'b0);
        check_eq("to_early_ready", bus.s_ready, 1'b0);
      end
      if (k == 9) begin
        check_eq("to_flag", timeout_err, 1'b1);
        check_eq("to_ready", bus.s_ready, 1'b1);
        check_eq("to_busy", busy, 1'b0);
        check_eq("to_m_valid", bus.m_valid, 1'b0);
      end
    end

    // Next block completes normally; the flag stays set.
    do_block(KEY2, PT2, CT2, 1'b1, -1, 0, 4);
    check_eq("to_sticky", timeout_err, 1'b1);

    // Reset in the middle of draining, after two words.
    do_block(KEY1, PT1, CT1, 1'b1, -1, 0, 2);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_m_valid", bus.m_valid, 1'b0);
    check_eq("mid_rst_m_data", bus.m_data, 32'h0);
    check_eq("mid_rst_timeout", timeout_err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_s_ready", bus.s_ready, 1'b1);
    do_block(KEY2, PT2, CT2, 1'b1, -1, 0, 4);

`ifdef AES_KEY_REUSE_EN
    // Key retained: stray strobe in LOAD_PT, then plaintext only.
    check_eq("reuse_idle_busy", busy, 1'b0);
    aes_ciphertext = CT1;
    aes_valid      = 1'b1;
    @(negedge clk);
    aes_valid      = 1'b0;
    aes_ciphertext = 128'h0;
    check_eq("reuse_spurious_m_valid", bus.m_valid, 1'b0);
    check_eq("reuse_spurious_ready", bus.s_ready, 1'b1);
    do_block(KEY2, PT1, CT1, 1'b0, -1, 0, 4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_word_bridge.md
AES_WORD_BRIDGE -- requirements
Module: aes_word_bridge

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 64: maximum cycles in WAIT for aes_valid before timeout.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port s_valid  input  1  upstream word valid.
REQ-005 SHALL have port s_ready  output  1  upstream word accept.
REQ-006 SHALL have port s_data  input  32  upstream key/plaintext word.
REQ-007 SHALL have port s_key  input  1  word is key word; used only with AES_KEY_REUSE_EN.
REQ-008 SHALL have port aes_start  output  1  one-cycle start pulse to AES engine.
REQ-009 SHALL have port aes_key  output  128  assembled key.
REQ-010 SHALL have port aes_plaintext  output  128  assembled plaintext.
REQ-011 SHALL have port aes_ciphertext  input  128  engine result.
REQ-012 SHALL have port aes_valid  input  1  engine result valid, single-cycle pulse.
REQ-013 SHALL have port m_valid  output  1  downstream ciphertext word valid.
REQ-014 SHALL have port m_ready  input  1  downstream accept.
REQ-015 SHALL have port m_data  output  32  ciphertext word.
REQ-016 SHALL have port m_last  output  1  marks 4th ciphertext word.
REQ-017 SHALL have port busy  output  1  high in any state except LOAD_KEY/LOAD_PT with zero words held.
REQ-018 SHALL have port timeout_err  output  1  sticky timeout flag.

Function
REQ-019 SHALL implement states LOAD_KEY, LOAD_PT, START, WAIT, DRAIN.
REQ-020 SHALL accept a word when s_valid && s_ready; s_ready high only in LOAD_KEY and LOAD_PT.
REQ-021 SHALL pack words big-endian: first word accepted -> bits [127:96], fourth -> [31:0].
REQ-022 SHALL move LOAD_KEY -> LOAD_PT after the 4th key word, LOAD_PT -> START after the 4th plaintext word.
REQ-023 SHALL assert aes_start for exactly one cycle in START, i.e. the cycle after the last plaintext word is accepted, then enter WAIT.
REQ-024 SHALL hold aes_key and aes_plaintext stable from START until return to a LOAD state.
REQ-025 SHALL, in WAIT, capture aes_ciphertext on aes_valid and enter DRAIN next cycle.
REQ-026 SHALL ignore aes_valid in any state other than WAIT.
REQ-027 SHALL count WAIT cycles; on reaching WAIT_LIMIT without aes_valid, set timeout_err, discard the block, return to LOAD_KEY (LOAD_PT under AES_KEY_REUSE_EN with a key held).
REQ-028 SHALL, in DRAIN, present ciphertext words MSW first, m_valid high, m_data/m_last stable while m_valid && !m_ready.
REQ-029 SHALL advance a word only on m_valid && m_ready; after the m_last handshake leave DRAIN the next cycle.
REQ-030 SHALL sustain one word per cycle in LOAD and DRAIN when the partner is always ready.

Reset
REQ-031 SHALL on rst_n low force LOAD_KEY, all counters 0, s_ready 0 during reset then 1, aes_start 0, m_valid 0, m_last 0, m_data 0, aes_key 0, aes_plaintext 0, timeout_err 0, busy 0.
REQ-032 SHALL discard any partial block on reset mid-operation; timeout_err clears only on reset.

Configuration
REQ-033 SHALL support macro AES_KEY_REUSE_EN.
REQ-034 Without AES_KEY_REUSE_EN SHALL require 4 key + 4 plaintext words per block; s_key ignored; after DRAIN return to LOAD_KEY.
REQ-035 With AES_KEY_REUSE_EN SHALL retain key after DRAIN and return to LOAD_PT; a word with s_key=1 in LOAD_PT (no plaintext words held) SHALL switch to LOAD_KEY and count as key word 1; s_key=1 mid-plaintext SHALL be ignored as a key and taken as plaintext.

Structure
REQ-036 SHALL place state enum, AES_WORDS=4 and word width constant in shared package aes_pkg.
REQ-037 SHALL use one sub-module aes_word_pack (4x32 shift-in register with word counter), instantiated for key and plaintext.

Verification
REQ-038 FIPS-197 vector: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, model returns 69c4e0d86a7b0430d8cdb78070b4c55a -> m_data 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a, m_last on 4th.
REQ-039 Back-pressure: m_ready low 3 cycles on word 2 -> m_data held at 6a7b0430, no word lost or duplicated.
REQ-040 Timeout: WAIT_LIMIT=8, model never asserts aes_valid -> timeout_err high at cycle 8 of WAIT, state returns to load, next block completes normally.
REQ-041 Reset mid-DRAIN after word 2 -> m_valid 0 next cycle, fresh block yields full 4 words.
REQ-042 With AES_KEY_REUSE_EN: second block of 4 plaintext words only -> aes_start issued with original key; spurious aes_valid in LOAD_PT ignored.
